// File: rtl/thor2022_regfile_valid.sv
// Thor2022 per-register "value present in register file" tracker with pending count.
// Optional: define THOR2022_REGVALID_RT2_EN to also track the Rt2 decode target.
module thor2022_regfile_valid #(
    parameter int NREGS       = 64,
    parameter int REB_ENTRIES = 8,
    parameter int NOSRC       = 31
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   branchmiss,
    input  logic [NREGS-1:0]       livetarget,
    input  logic [NREGS-1:0]       livetarget2,
    input  logic                   commit0_wr,
    input  logic [5:0]             commit0_id,
    input  logic [5:0]             commit0_tgt,
    input  logic                   commit1_wr,
    input  logic [5:0]             commit1_id,
    input  logic [5:0]             commit1_tgt,
    input  logic [6*NREGS-1:0]     regfile_src,
    input  logic [REB_ENTRIES-1:0] reb_decompressed,
    input  logic [2:0]             dec0,
    input  logic [2:0]             dec1,
    input  logic                   decbus0_rfwr,
    input  logic [6:0]             decbus0_rt,
    input  logic [6:0]             decbus0_rt2,
    input  logic                   decbus1_rfwr,
    input  logic [6:0]             decbus1_rt,
    input  logic [6:0]             decbus1_rt2,
    output logic [NREGS-1:0]       regfile_valid,
    output logic [6:0]             pending_cnt
);

    logic             dec0_act;
    logic             dec1_act;
    logic [NREGS-1:0] lt_any;
    logic [NREGS-1:0] valid_nxt;
    logic [6:0]       cnt_nxt;
    logic [5:0]       src_n;
    logic             set_n;
    logic             clr_n;

    assign dec0_act = (dec0 != 3'd7) && reb_decompressed[dec0]
                      && decbus0_rfwr;
    assign dec1_act = dec0_act && (dec1 != 3'd7)
                      && reb_decompressed[dec1] && decbus1_rfwr;

`ifdef THOR2022_REGVALID_RT2_EN
    assign lt_any = livetarget | livetarget2;
`else
    logic unused_rt2;
    assign lt_any     = livetarget;
    assign unused_rt2 = ^{livetarget2, decbus0_rt2, decbus1_rt2};
`endif

    // Indices are compared in 32 bits so out-of-range Rt never aliases a real reg.
    always_comb begin
        valid_nxt = regfile_valid;
        cnt_nxt   = '0;
        src_n     = '0;
        set_n     = 1'b0;
        clr_n     = 1'b0;
        for (int n = 0; n < NREGS; n++) begin
            src_n = regfile_src[n*6 +: 6];
            set_n = (commit0_wr && (32'(commit0_tgt) == n)
                     && (src_n == commit0_id))
                 || (commit1_wr && (32'(commit1_tgt) == n)
                     && (src_n == commit1_id));
            clr_n = (dec0_act && (32'(decbus0_rt) == n))
                 || (dec1_act && (32'(decbus1_rt) == n));
`ifdef THOR2022_REGVALID_RT2_EN
            clr_n = clr_n
                 || (dec0_act && (32'(decbus0_rt2) == n))
                 || (dec1_act && (32'(decbus1_rt2) == n));
`endif
            if (n == 0)
                valid_nxt[n] = 1'b1;
            else if (branchmiss)
                valid_nxt[n] = ~lt_any[n];
            else if (clr_n)
                valid_nxt[n] = 1'b0;
            else if (set_n)
                valid_nxt[n] = 1'b1;
            cnt_nxt = cnt_nxt + 7'(!valid_nxt[n]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regfile_valid <= '1;
            pending_cnt   <= '0;
        end else begin
            regfile_valid <= valid_nxt;
            pending_cnt   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_thor2022_regfile_valid.sv
// Scoreboard bench for thor2022_regfile_valid: stimulus pushes expected state,
// a monitor pops and compares one cycle later.
module tb_thor2022_regfile_valid;

    localparam int NREGS = 64;
    localparam logic [63:0] ALL1 = '1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 branchmiss;
    logic [NREGS-1:0]     livetarget;
    logic [NREGS-1:0]     livetarget2;
    logic                 commit0_wr;
    logic [5:0]           commit0_id;
    logic [5:0]           commit0_tgt;
    logic                 commit1_wr;
    logic [5:0]           commit1_id;
    logic [5:0]           commit1_tgt;
    logic [6*NREGS-1:0]   regfile_src;
    logic [7:0]           reb_decompressed;
    logic [2:0]           dec0;
    logic [2:0]           dec1;
    logic                 decbus0_rfwr;
    logic [6:0]           decbus0_rt;
    logic [6:0]           decbus0_rt2;
    logic                 decbus1_rfwr;
    logic [6:0]           decbus1_rt;
    logic [6:0]           decbus1_rt2;
    logic [NREGS-1:0]     regfile_valid;
    logic [6:0]           pending_cnt;

    int tests  = 0;
    int fails  = 0;
    logic [70:0] sb[$];
    logic [63:0] ev;

    thor2022_regfile_valid dut (
        .clk(clk), .rst(rst), .branchmiss(branchmiss),
        .livetarget(livetarget), .livetarget2(livetarget2),
        .commit0_wr(commit0_wr), .commit0_id(commit0_id),
        .commit0_tgt(commit0_tgt),
        .commit1_wr(commit1_wr), .commit1_id(commit1_id),
        .commit1_tgt(commit1_tgt),
        .regfile_src(regfile_src),
        .reb_decompressed(reb_decompressed),
        .dec0(dec0), .dec1(dec1),
        .decbus0_rfwr(decbus0_rfwr), .decbus0_rt(decbus0_rt),
        .decbus0_rt2(decbus0_rt2),
        .decbus1_rfwr(decbus1_rfwr), .decbus1_rt(decbus1_rt),
        .decbus1_rt2(decbus1_rt2),
        .regfile_valid(regfile_valid), .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
        rst = 0; branchmiss = 0;
        livetarget = '0; livetarget2 = '0;
        commit0_wr = 0; commit0_id = '0; commit0_tgt = '0;
        commit1_wr = 0; commit1_id = '0; commit1_tgt = '0;
        reb_decompressed = '0; dec0 = 3'd7; dec1 = 3'd7;
        decbus0_rfwr = 0; decbus0_rt = '0; decbus0_rt2 = '0;
        decbus1_rfwr = 0; decbus1_rt = '0; decbus1_rt2 = '0;
    endtask

    task automatic expect_v(input logic [63:0] v);
        sb.push_back({v, 7'($countones(~v))});
    endtask

    task automatic set_src(input int n, input logic [5:0] t);
        regfile_src[n*6 +: 6] = t;
    endtask

    // Monitor: outputs are meaningful every cycle, one entry per stimulus cycle.
    initial begin
        logic [70:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                tests++;
                if (regfile_valid !== e[70:7]) begin
                    fails++;
                    $display("FAIL valid got=%h exp=%h",
                             regfile_valid, e[70:7]);
                end
                tests++;
                if (pending_cnt !== e[6:0]) begin
                    fails++;
                    $display("FAIL pending_cnt got=%0d exp=%0d",
                             pending_cnt, e[6:0]);
                end
            end
        end
    end

    initial begin
        regfile_src = {NREGS{6'd31}};
        // reset overrides a simultaneous decode
        cyc(); rst = 1;
        dec0 = 3'd2; reb_decompressed = 8'h04;
        decbus0_rfwr = 1; decbus0_rt = 7'd5;
        expect_v(ALL1);
        // decode clears reg 5
        cyc(); dec0 = 3'd2; reb_decompressed = 8'h04;
        decbus0_rfwr = 1; decbus0_rt = 7'd5;
        ev = ALL1; ev[5] = 0; expect_v(ev);
        // matching commit sets it
        cyc(); set_src(5, 6'd2);
        commit0_wr = 1; commit0_id = 6'd2; commit0_tgt = 6'd5;
        expect_v(ALL1);
        // decode clear beats same-cycle commit
        cyc(); dec0 = 3'd1; reb_decompressed = 8'h02;
        decbus0_rfwr = 1; decbus0_rt = 7'd5;
        commit1_wr = 1; commit1_id = 6'd2; commit1_tgt = 6'd5;
        ev = ALL1; ev[5] = 0; expect_v(ev);
        // stale tag: no change
        cyc(); set_src(5, 6'd4);
        commit0_wr = 1; commit0_id = 6'd2; commit0_tgt = 6'd5;
        expect_v(ev);
        // both ports hit reg 5
        cyc();
        commit0_wr = 1; commit0_id = 6'd4; commit0_tgt = 6'd5;
        commit1_wr = 1; commit1_id = 6'd4; commit1_tgt = 6'd5;
        expect_v(ALL1);
        // dual decode: 5 and 9
        cyc(); dec0 = 3'd0; dec1 = 3'd3; reb_decompressed = 8'h09;
        decbus0_rfwr = 1; decbus0_rt = 7'd5;
        decbus1_rfwr = 1; decbus1_rt = 7'd9;
        ev = ALL1; ev[5] = 0; ev[9] = 0; expect_v(ev);
        // branchmiss restores from livetarget, ignores decode
        cyc(); branchmiss = 1;
        livetarget[9] = 1; livetarget2[20] = 1;
        dec0 = 3'd0; reb_decompressed = 8'h01;
        decbus0_rfwr = 1; decbus0_rt = 7'd12;
        ev = ALL1; ev[9] = 0;
`ifdef THOR2022_REGVALID_RT2_EN
        ev[20] = 0;
`endif
        expect_v(ev);
        // decode to reg 0 keeps it valid
        cyc(); dec0 = 3'd4; reb_decompressed = 8'h10;
        decbus0_rfwr = 1; decbus0_rt = 7'd0;
        expect_v(ev);
        // Rt and Rt2
        cyc(); dec0 = 3'd4; reb_decompressed = 8'h10;
        decbus0_rfwr = 1; decbus0_rt = 7'd3; decbus0_rt2 = 7'd4;
        ev[3] = 0;
`ifdef THOR2022_REGVALID_RT2_EN
        ev[4] = 0;
`endif
        expect_v(ev);
        // slot 1 alone is not active; slot 0 not decompressed
        cyc(); dec1 = 3'd2; reb_decompressed = 8'h05;
        decbus1_rfwr = 1; decbus1_rt = 7'd7;
        dec0 = 3'd1; decbus0_rfwr = 1; decbus0_rt = 7'd8;
        expect_v(ev);
        // rfwr low: no clear
        cyc(); dec0 = 3'd2; reb_decompressed = 8'h04;
        decbus0_rfwr = 0; decbus0_rt = 7'd10;
        expect_v(ev);
        // out-of-range Rt ignored (no wrap to 0/6)
        cyc(); dec0 = 3'd2; reb_decompressed = 8'h04;
        decbus0_rfwr = 1; decbus0_rt = 7'd70;
        expect_v(ev);
        // branchmiss with many live targets, reg 0 never counted
        cyc(); branchmiss = 1;
        livetarget = 64'hF000_0000_0000_00F1;
        ev = ~64'hF000_0000_0000_00F0;
`ifdef THOR2022_REGVALID_RT2_EN
        livetarget2[33] = 1; ev[33] = 0;
`endif
        expect_v(ev);
        // commit with NOSRC tag never matches
        cyc(); set_src(4, 6'd31);
        commit0_wr = 1; commit0_id = 6'd7; commit0_tgt = 6'd4;
        expect_v(ev);
        // mid-flight reset
        cyc(); rst = 1;
        expect_v(ALL1);
        cyc();
        expect_v(ALL1);
        for (int i = 0; i < 20 && sb.size() > 0; i++)
            @(posedge clk);
        #2;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain left=%0d exp=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
